// File: rtl/seg_scan_pkg.sv
// Shared definitions for the 7-segment scan controller: FSM states, register field
// positions and the control register address.
package seg_scan_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShow  = 2'd1,
      StBlank = 2'd2
   } state_e;

   // Digit register fields
   localparam int unsigned NIB_LSB = 0;
   localparam int unsigned DOT_BIT = 4;
   localparam int unsigned EN_BIT  = 7;

   // Control register
   localparam logic [3:0]  CTRL_ADDR   = 4'd15;
   localparam int unsigned SCAN_EN_BIT = 0;
   localparam int unsigned BRIGHT_LSB  = 1;

   // Keep nibble, dot and enable; reserved bits [6:5] are stored as zero.
   function automatic logic [7:0] digit_mask(input logic [7:0] w);
      return {w[EN_BIT], 2'b00, w[DOT_BIT], w[NIB_LSB +: 4]};
   endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Loadable down-counter shared by the SHOW dwell and BLANK gap intervals.
// Stops at zero; a load strobe overrides the decrement.
module seg_scan_timer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic [CNT_W-1:0] count_o,
   output logic             zero_o
);

   logic [CNT_W-1:0] count_q, count_d;

   // Next count: load wins, otherwise decrement and hold at zero
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (count_q != '0) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign zero_o  = (count_q == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered digit register file written
// from the bus, and an IDLE/SHOW/BLANK scan FSM driving a shared decoder plus one-hot
// digit enables. All outputs are registered.
// Optional build macro SEG_SCAN_BRIGHTNESS_EN: gates OE to the first
// ((brightness+1)*DWELL)/8 cycles of each SHOW slot.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int unsigned NDIGITS   = 4,
   parameter int unsigned DWELL     = 1000,
   parameter int unsigned BLANK_CYC = 16,
   parameter int unsigned CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [3:0]         waddr,
   input  logic [7:0]         wdata,
   output logic               OE,
   output logic [3:0]         tetrade,
   output logic               dot,
   output logic [NDIGITS-1:0] digit_en,
   output logic               frame_tick
);

   localparam int unsigned      IdxW    = $clog2(NDIGITS);
   localparam logic [CNT_W-1:0] DwellLd = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] BlankLd = CNT_W'(BLANK_CYC - 1);
   localparam logic [IdxW-1:0]  LastIdx = IdxW'(NDIGITS - 1);

   // Register file and control
   logic [NDIGITS-1:0][7:0] shadow_q, shadow_d;
   logic [NDIGITS-1:0][7:0] live_q, live_d;
   logic                    scan_en_q, scan_en_d;
`ifdef SEG_SCAN_BRIGHTNESS_EN
   logic [2:0]              bright_q, bright_d;
`endif

   // Scan FSM
   state_e                  state_q, state_d;
   logic [IdxW-1:0]         idx_q, idx_d;
   logic                    commit;
   logic                    tmr_load;
   logic [CNT_W-1:0]        tmr_val;
   logic [CNT_W-1:0]        cnt;
   logic                    tmr_zero;

   // Output registers
   logic                    oe_q, oe_d;
   logic [3:0]              tetrade_q, tetrade_d;
   logic                    dot_q, dot_d;
   logic [NDIGITS-1:0]      digit_en_q, digit_en_d;
   logic                    frame_tick_q, frame_tick_d;

   logic [7:0]              sel;
   logic                    bright_ok;
   logic                    show_on;

   seg_scan_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .count_o    (cnt),
      .zero_o     (tmr_zero)
   );

   // Bus writes: digit data goes to the shadow bank only; commit copies shadow to live
   always_comb begin
      shadow_d  = shadow_q;
      scan_en_d = scan_en_q;
`ifdef SEG_SCAN_BRIGHTNESS_EN
      bright_d  = bright_q;
`endif
      if (we) begin
         if (waddr == CTRL_ADDR) begin
            scan_en_d = wdata[SCAN_EN_BIT];
`ifdef SEG_SCAN_BRIGHTNESS_EN
            bright_d  = wdata[BRIGHT_LSB +: 3];
`endif
         end else if (32'(waddr) < NDIGITS) begin
            shadow_d[waddr[IdxW-1:0]] = digit_mask(wdata);
         end
      end
      // Commit samples the pre-write shadow, so a colliding write waits a frame
      live_d = commit ? shadow_q : live_q;
   end

   // Scan sequencing: dwell on a digit, blank gap, advance; commit at frame start
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      commit   = 1'b0;
      unique case (state_q)
         StIdle: begin
            tmr_load = 1'b1;
            if (scan_en_q) begin
               state_d = StShow;
               idx_d   = '0;
               commit  = 1'b1;
               tmr_val = DwellLd;
            end
         end
         StShow: begin
            if (tmr_zero) begin
               state_d  = StBlank;
               tmr_load = 1'b1;
               tmr_val  = BlankLd;
            end
         end
         StBlank: begin
            if (tmr_zero) begin
               state_d  = StShow;
               tmr_load = 1'b1;
               tmr_val  = DwellLd;
               if (idx_q == LastIdx) begin
                  idx_d  = '0;
                  commit = 1'b1;
               end else begin
                  idx_d = idx_q + IdxW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
      // Disable overrides everything and parks the scan cleanly
      if (!scan_en_q) begin
         state_d  = StIdle;
         idx_d    = '0;
         tmr_load = 1'b1;
         tmr_val  = '0;
         commit   = 1'b0;
      end
   end

`ifdef SEG_SCAN_BRIGHTNESS_EN
   localparam int unsigned MulW = CNT_W + 4;
   logic [MulW-1:0]  bright_thr;
   logic [CNT_W-1:0] cnt_next;

   // Lit while the next-cycle count is in the top T values of the dwell countdown
   always_comb begin
      bright_thr = MulW'(DWELL) -
                   (((MulW'(bright_q) + MulW'(1)) * MulW'(DWELL)) >> 3);
      cnt_next   = (state_q == StShow) ? (cnt - CNT_W'(1)) : DwellLd;
      bright_ok  = (MulW'(cnt_next) >= bright_thr);
   end
`else
   logic unused_cnt;
   assign unused_cnt = ^cnt;
   assign bright_ok  = 1'b1;
`endif

   // Next registered outputs; a committing cycle sources the digit straight from shadow
   always_comb begin
      sel               = commit ? shadow_q[idx_d] : live_q[idx_d];
      show_on           = (state_d == StShow) && sel[EN_BIT] && bright_ok;
      oe_d              = show_on;
      digit_en_d        = '0;
      digit_en_d[idx_d] = show_on;
      tetrade_d         = tetrade_q;
      dot_d             = dot_q;
      if (state_d == StIdle) begin
         tetrade_d = '0;
         dot_d     = 1'b0;
      end else if ((state_d == StShow) && (state_q != StShow)) begin
         tetrade_d = sel[NIB_LSB +: 4];
         dot_d     = sel[DOT_BIT];
      end
      frame_tick_d = commit;
   end

   // State, register file and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q     <= '0;
         live_q       <= '0;
         scan_en_q    <= 1'b0;
`ifdef SEG_SCAN_BRIGHTNESS_EN
         bright_q     <= '0;
`endif
         state_q      <= StIdle;
         idx_q        <= '0;
         oe_q         <= 1'b0;
         tetrade_q    <= '0;
         dot_q        <= 1'b0;
         digit_en_q   <= '0;
         frame_tick_q <= 1'b0;
      end else begin
         shadow_q     <= shadow_d;
         live_q       <= live_d;
         scan_en_q    <= scan_en_d;
`ifdef SEG_SCAN_BRIGHTNESS_EN
         bright_q     <= bright_d;
`endif
         state_q      <= state_d;
         idx_q        <= idx_d;
         oe_q         <= oe_d;
         tetrade_q    <= tetrade_d;
         dot_q        <= dot_d;
         digit_en_q   <= digit_en_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign OE         = oe_q;
   assign tetrade    = tetrade_q;
   assign dot        = dot_q;
   assign digit_en   = digit_en_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Multiplexed scan controller for a bank of 7-segment + dot digits, each driven through the shared 8-segment decoder.
- Holds a per-digit value/dot/enable register file, double-buffered, written by the MCS-51 peripheral bus.
- Time-multiplexes the single decoder across digits, with an inter-digit blanking gap to suppress ghosting.
- Outputs: tetrade/dot/OE to the decoder, and one-hot digit enables to the common-pin drivers.

Parameters:
- NDIGITS, 4: number of multiplexed digits (2..8).
- DWELL, 1000: clock cycles each digit is shown (≥2).
- BLANK_CYC, 16: clock cycles all digits are off between digits (≥1).
- CNT_W, 16: dwell/blank counter width; must hold max(DWELL, BLANK_CYC)-1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- we  in  1  bus write strobe, one cycle per write.
- waddr  in  4  register address: 0..NDIGITS-1 = digit shadow regs; 15 = control reg; all others ignored.
- wdata  in  8  write data.
- OE  out  1  decoder output enable.
- tetrade  out  4  nibble for the decoder.
- dot  out  1  dot bit for the decoder.
- digit_en  out  NDIGITS  one-hot digit common select, active-high.
- frame_tick  out  1  one-cycle pulse when a new frame commits.

Behaviour:
- Digit register fields: wdata[3:0] = nibble; [4] = dot; [7] = digit enable; [6:5] reserved, stored as 0.
- Control register fields: wdata[0] = scan_en; [3:1] = brightness (used only under the optional feature); others ignored.
- Control writes take effect at the next edge.
- Digit writes land in the shadow bank only.
- Live bank: loaded from the whole shadow bank in a single cycle ("commit") on IDLE→SHOW and on the BLANK→SHOW wrap from digit NDIGITS-1 to digit 0. frame_tick is high the cycle after each commit.
- Write/commit collision: a shadow write in the same cycle as a commit is not committed that frame. It lands in shadow and commits at the next frame.
- Reset values: all outputs 0; state IDLE; idx 0; counter 0; shadow, live and control registers all 0.
- All outputs are registered.
- IDLE:
  - OE = 0, digit_en = 0, tetrade = 0, dot = 0.
  - scan_en = 1 → SHOW with idx = 0, plus commit.
  - Write scan_en = 1 at edge N → first SHOW outputs visible after edge N+1.
- SHOW:
  - Counter loaded with DWELL-1 on entry; decrements each cycle.
  - On entry, tetrade and dot take live[idx]. They hold through the following BLANK.
  - digit_en[idx] = OE = live_en[idx]; other digit_en bits are 0.
  - Counter reaches 0 → BLANK.
- BLANK:
  - OE = 0, digit_en = 0; counter loaded with BLANK_CYC-1.
  - Counter reaches 0 → SHOW with idx+1. idx wraps from NDIGITS-1 to 0, and the wrap performs a commit.
- Period: each digit period is exactly DWELL+BLANK_CYC cycles. A frame is NDIGITS×(DWELL+BLANK_CYC) cycles.
- scan_en cleared in any state → IDLE at the next edge. All outputs go to 0 at that edge; idx and counter clear.
- Re-enabling restarts at digit 0 with a fresh commit.
- Digit with live enable 0: its SHOW slot still elapses with OE = 0 and digit_en = 0, so timing is unchanged.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous). Shadow contents are lost.

Optional Feature:
- Macro: SEG_SCAN_BRIGHTNESS_EN.
- Defined: the SHOW slot is gated by a brightness threshold.
  - T = ((brightness+1)×DWELL)/8, computed as a constant-width multiply then shift.
  - OE and digit_en are asserted only for the first T cycles of SHOW, and are 0 for the rest.
  - brightness 7 = full DWELL.
- Undefined: control bits [3:1] are ignored and not stored; OE is high for the whole SHOW slot.
- Slot and frame timing are identical in both builds.

Decomposition:
- Package seg_scan_pkg:
  - State encoding IDLE/SHOW/BLANK.
  - Digit field bit positions (NIB_LSB = 0, DOT_BIT = 4, EN_BIT = 7).
  - CTRL_ADDR = 15, SCAN_EN_BIT = 0, BRIGHT_LSB = 1.
- Sub-module seg_scan_timer: loadable down-counter with load value input, load strobe and zero flag. It is reused for both SHOW and BLANK.
- Register file and FSM stay in the top level.

Test Plan:
- Reset, then enable with DWELL = 4, BLANK_CYC = 2, NDIGITS = 4, and digits 0..3 written 0x81, 0x92, 0x83, 0x84 before enable:
  - digit_en sequence 0001, 0010, 0100, 1000, each high 4 cycles, separated by 2-cycle all-zero gaps.
  - tetrade = 1, 2, 3, 4; dot high only on digit 1.
  - frame_tick every 24 cycles.
- Mid-frame write of 0x85 to digit 0 → the current frame still shows 1 on digit 0; from the next frame it shows 5.
- Write to digit 0 in the exact commit cycle → not visible until the following frame.
- Digit 2 written 0x03 (enable 0) → during slot 2, OE = 0 and digit_en = 0; the slot is still 4 cycles and the frame is still 24 cycles.
- Clear scan_en mid-SHOW of digit 1, then set it again → all outputs 0 at the next edge; restart at digit 0 with frame_tick.
- SEG_SCAN_BRIGHTNESS_EN defined, DWELL = 8, brightness 1 → OE high 2 of 8 SHOW cycles; brightness 7 → 8 of 8.
- Assert rst during BLANK → all outputs 0 immediately; shadow registers read as 0 after a re-enable.
